zeroriscy_wb_stage: RTL and testbench

Writeback stage directly downstream of the execute block: takes the EX-stage result (ALU, MUL/DIV or custom0 value) or a pending load, and turns it into one registered register-file write per instruction. Load data is aligned and sign/zero-extended here rather than in EX. The stage also exposes a forwarding port so decode can bypass the in-flight write. Loads are handled by a small FSM that holds back EX until the data-memory response arrives or is drained after a flush.

---
 rtl/zeroriscy_wb_stage.sv | 174 +++++++++++++++++
 tb/tb_zeroriscy_wb_stage.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/zeroriscy_wb_stage.sv
// zeroriscy_wb_stage: writeback stage after EX. It turns each retiring instruction
// into one registered register-file write. Load data is aligned and sign/zero-extended
// here, and a small FSM holds EX off while a load response is outstanding.
// Latency: a non-load accepted in cycle N writes in N+1. A load response in cycle M
// writes in M+1.
// Backpressure: wb_ready_o drops while a load waits for its response or drains it.
// Ports: ex_* = instruction from EX, wb_ready_o = accept handshake, flush_i = kill,
//        lsu_* = data-memory response, rf_* = register-file write,
//        fwd_* = bypass to decode, load_err_o = load bus-error pulse.
// Optional feature: define ZERORISCY_WB_FWD_EN to drive the forwarding port.
// Without it, fwd_* is tied to zero.
module zeroriscy_wb_stage #(
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ex_valid_i,
  input  logic                  ex_we_i,
  input  logic [ADDR_WIDTH-1:0] ex_waddr_i,
  input  logic [31:0]           ex_wdata_i,
  input  logic                  ex_is_load_i,
  input  logic [1:0]            ex_load_type_i,
  input  logic                  ex_load_sign_i,
  input  logic [1:0]            ex_addr_lsb_i,
  output logic                  wb_ready_o,
  input  logic                  flush_i,
  input  logic                  lsu_rvalid_i,
  input  logic [31:0]           lsu_rdata_i,
  input  logic                  lsu_err_i,
  output logic                  rf_we_o,
  output logic [ADDR_WIDTH-1:0] rf_waddr_o,
  output logic [31:0]           rf_wdata_o,
  output logic                  fwd_valid_o,
  output logic [ADDR_WIDTH-1:0] fwd_waddr_o,
  output logic [31:0]           fwd_wdata_o,
  output logic                  load_err_o
);

  typedef enum logic [1:0] {IDLE, WRITE, WAIT_LOAD, DRAIN} state_e;

  state_e                state_q, state_d;
  logic                  rf_we_q, rf_we_d;
  logic [ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
  logic [31:0]           rf_wdata_q, rf_wdata_d;
  logic                  load_err_q, load_err_d;
  // Context of the outstanding load. It is kept apart from rf_* so that the
  // visible write port stays stable while the load is in flight.
  logic                  ld_we_q, ld_we_d;
  logic [ADDR_WIDTH-1:0] ld_waddr_q, ld_waddr_d;
  logic [1:0]            ld_type_q, ld_type_d;
  logic                  ld_sign_q, ld_sign_d;
  logic [1:0]            ld_lsb_q, ld_lsb_d;
  logic                  accept;

  function automatic logic [31:0] extract(input logic [1:0] ty, input logic sg,
                                          input logic [1:0] lsb, input logic [31:0] d);
    logic [15:0] h;
    logic [7:0]  b;
    h = lsb[1] ? d[31:16] : d[15:0];
    case (lsb)
      2'd0:    b = d[7:0];
      2'd1:    b = d[15:8];
      2'd2:    b = d[23:16];
      default: b = d[31:24];
    endcase
    case (ty)
      2'b01:   return {{16{sg & h[15]}}, h};
      2'b10:   return {{24{sg & b[7]}}, b};
      default: return d;  // word and the reserved encoding
    endcase
  endfunction

  assign wb_ready_o = (state_q == IDLE) || (state_q == WRITE);
  // A flush in the same cycle as ex_valid_i wins, so nothing is accepted.
  assign accept     = ex_valid_i & wb_ready_o & ~flush_i;

  always_comb begin
    state_d    = state_q;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    load_err_d = 1'b0;
    ld_we_d    = ld_we_q;
    ld_waddr_d = ld_waddr_q;
    ld_type_d  = ld_type_q;
    ld_sign_d  = ld_sign_q;
    ld_lsb_d   = ld_lsb_q;
    case (state_q)
      IDLE, WRITE: begin
        // Stray lsu responses seen here belong to nobody and are ignored.
        state_d = IDLE;
        if (accept) begin
          if (ex_is_load_i) begin
            state_d    = WAIT_LOAD;
            ld_we_d    = ex_we_i & (ex_waddr_i != '0);
            ld_waddr_d = ex_waddr_i;
            ld_type_d  = ex_load_type_i;
            ld_sign_d  = ex_load_sign_i;
            ld_lsb_d   = ex_addr_lsb_i;
          end else begin
            state_d    = WRITE;
            rf_we_d    = ex_we_i & (ex_waddr_i != '0);
            rf_waddr_d = ex_waddr_i;
            rf_wdata_d = ex_wdata_i;
          end
        end
      end
      WAIT_LOAD: begin
        if (lsu_rvalid_i) begin
          if (flush_i) begin
            state_d = IDLE;            // the response dies with the flushed load
          end else if (lsu_err_i) begin
            state_d    = IDLE;
            load_err_d = 1'b1;
          end else begin
            state_d    = WRITE;
            rf_we_d    = ld_we_q;
            rf_waddr_d = ld_waddr_q;
            rf_wdata_d = extract(ld_type_q, ld_sign_q, ld_lsb_q, lsu_rdata_i);
          end
        end else if (flush_i) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Swallow the response of the killed load silently, error or not.
        if (lsu_rvalid_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      load_err_q <= 1'b0;
      ld_we_q    <= 1'b0;
      ld_waddr_q <= '0;
      ld_type_q  <= 2'b00;
      ld_sign_q  <= 1'b0;
      ld_lsb_q   <= 2'b00;
    end else begin
      state_q    <= state_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      load_err_q <= load_err_d;
      ld_we_q    <= ld_we_d;
      ld_waddr_q <= ld_waddr_d;
      ld_type_q  <= ld_type_d;
      ld_sign_q  <= ld_sign_d;
      ld_lsb_q   <= ld_lsb_d;
    end
  end

  assign rf_we_o    = rf_we_q;
  assign rf_waddr_o = rf_waddr_q;
  assign rf_wdata_o = rf_wdata_q;
  assign load_err_o = load_err_q;

`ifdef ZERORISCY_WB_FWD_EN
  assign fwd_valid_o = rf_we_q;
  assign fwd_waddr_o = rf_waddr_q;
  assign fwd_wdata_o = rf_wdata_q;
`else
  assign fwd_valid_o = 1'b0;
  assign fwd_waddr_o = '0;
  assign fwd_wdata_o = '0;
`endif

endmodule

// File: tb/tb_zeroriscy_wb_stage.sv
// Testbench for zeroriscy_wb_stage: directed cases followed by randomized
// non-load and load transactions. Expected load data is computed arithmetically
// from the byte/half/word extension rules.
module tb_zeroriscy_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid_i, ex_we_i, ex_is_load_i, ex_load_sign_i;
  logic [4:0]  ex_waddr_i;
  logic [31:0] ex_wdata_i;
  logic [1:0]  ex_load_type_i, ex_addr_lsb_i;
  logic        wb_ready_o, flush_i, lsu_rvalid_i, lsu_err_i;
  logic [31:0] lsu_rdata_i;
  logic        rf_we_o, fwd_valid_o, load_err_o;
  logic [4:0]  rf_waddr_o, fwd_waddr_o;
  logic [31:0] rf_wdata_o, fwd_wdata_o;

  int nerr = 0;
  int nchk = 0;

  zeroriscy_wb_stage #(.ADDR_WIDTH(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid_i(ex_valid_i), .ex_we_i(ex_we_i), .ex_waddr_i(ex_waddr_i),
    .ex_wdata_i(ex_wdata_i), .ex_is_load_i(ex_is_load_i),
    .ex_load_type_i(ex_load_type_i), .ex_load_sign_i(ex_load_sign_i),
    .ex_addr_lsb_i(ex_addr_lsb_i), .wb_ready_o(wb_ready_o), .flush_i(flush_i),
    .lsu_rvalid_i(lsu_rvalid_i), .lsu_rdata_i(lsu_rdata_i), .lsu_err_i(lsu_err_i),
    .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
    .fwd_valid_o(fwd_valid_o), .fwd_waddr_o(fwd_waddr_o), .fwd_wdata_o(fwd_wdata_o),
    .load_err_o(load_err_o)
  );

  always #5 clk = ~clk;

  // Reference extraction: pick the addressed field by byte offset and width,
  // then extend it to 32 bits.
  function automatic logic [31:0] model_ext(input logic [1:0] ty, input logic sg,
                                            input logic [1:0] lsb, input logic [31:0] rd);
    int nb, off;
    longint unsigned v, mask;
    nb  = (ty == 2'b01) ? 2 : (ty == 2'b10) ? 1 : 4;
    off = (ty == 2'b01) ? 2 * int'(lsb[1]) : (ty == 2'b10) ? int'(lsb) : 0;
    mask = (64'd1 << (8 * nb)) - 64'd1;
    v = (64'(rd) >> (8 * off)) & mask;
    if (sg && nb < 4 && ((v >> (8 * nb - 1)) & 64'd1) == 64'd1) v = v | ~mask;
    return v[31:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_ctl(input string tag, input logic exp_we, input logic exp_rdy,
                         input logic exp_err);
    chk({tag, ".we"},  32'(rf_we_o),    32'(exp_we));
    chk({tag, ".rdy"}, 32'(wb_ready_o), 32'(exp_rdy));
    chk({tag, ".err"}, 32'(load_err_o), 32'(exp_err));
`ifdef ZERORISCY_WB_FWD_EN
    chk({tag, ".fwd"}, 32'(fwd_valid_o), 32'(exp_we));
`else
    chk({tag, ".fwd"}, 32'(fwd_valid_o), 32'd0);
    chk({tag, ".fwdd"}, {27'd0, fwd_waddr_o} | fwd_wdata_o, 32'd0);
`endif
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    ex_valid_i = 0; ex_we_i = 0; ex_is_load_i = 0; flush_i = 0;
    lsu_rvalid_i = 0; lsu_err_i = 0;
  endtask

  task automatic put_ex(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic ld, input logic [1:0] ty, input logic sg,
                        input logic [1:0] lsb, input logic fl);
    ex_valid_i = 1; ex_we_i = we; ex_waddr_i = wa; ex_wdata_i = wd; ex_is_load_i = ld;
    ex_load_type_i = ty; ex_load_sign_i = sg; ex_addr_lsb_i = lsb; flush_i = fl;
  endtask

  // Non-load instruction, optionally killed by a flush in the same cycle.
  task automatic do_alu(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic fl);
    logic exp_we;
    put_ex(we, wa, wd, 1'b0, 2'b00, 1'b0, 2'b00, fl);
    step();
    idle_in();
    exp_we = !fl && we && wa != 0;
    chk_ctl("alu", exp_we, 1'b1, 1'b0);
    if (exp_we) begin
      chk("alu.waddr", 32'(rf_waddr_o), 32'(wa));
      chk("alu.wdata", rf_wdata_o, wd);
    end
    step();
    chk_ctl("alu.after", 1'b0, 1'b1, 1'b0);
  endtask

  // mode: 0 normal response, 1 error response, 2 flush then late response,
  // 3 flush coinciding with the response.
  task automatic do_load(input logic [4:0] wa, input logic [1:0] ty, input logic sg,
                         input logic [1:0] lsb, input logic [31:0] rd, input int dly,
                         input int mode);
    logic exp_we;
    put_ex(1'b1, wa, 32'h5A5A_5A5A, 1'b1, ty, sg, lsb, 1'b0);
    step();
    idle_in();
    chk_ctl("ld.acc", 1'b0, 1'b0, 1'b0);
    if (mode == 2) begin
      flush_i = 1;
      step();
      flush_i = 0;
      chk_ctl("ld.flush", 1'b0, 1'b0, 1'b0);
    end
    for (int i = 0; i < dly; i++) begin
      step();
      chk_ctl("ld.wait", 1'b0, 1'b0, 1'b0);
    end
    lsu_rvalid_i = 1; lsu_rdata_i = rd; lsu_err_i = (mode == 1); flush_i = (mode == 3);
    step();
    idle_in();
    exp_we = (mode == 0) && wa != 0;
    chk_ctl("ld.resp", exp_we, 1'b1, mode == 1);
    if (exp_we) begin
      chk("ld.waddr", 32'(rf_waddr_o), 32'(wa));
      chk("ld.wdata", rf_wdata_o, model_ext(ty, sg, lsb, rd));
    end
    step();
    chk_ctl("ld.after", 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    idle_in();
    ex_waddr_i = 0; ex_wdata_i = 0; ex_load_type_i = 0; ex_load_sign_i = 0;
    ex_addr_lsb_i = 0; lsu_rdata_i = 0;
    rst_n = 0;
    step();
    step();
    chk_ctl("reset", 1'b0, 1'b1, 1'b0);
    chk("reset.waddr", 32'(rf_waddr_o), 32'd0);
    chk("reset.wdata", rf_wdata_o, 32'd0);
    rst_n = 1;
    step();

    // Directed cases.
    do_alu(1'b1, 5'd5, 32'hDEADBEEF, 1'b0);
    do_load(5'd7, 2'b10, 1'b1, 2'd2, 32'h0080_0000, 1, 0);
    chk("plan.byte", rf_wdata_o, 32'hFFFF_FF80);
    do_load(5'd9, 2'b01, 1'b0, 2'd2, 32'h8001_1234, 0, 0);
    chk("plan.half", rf_wdata_o, 32'h0000_8001);
    do_load(5'd3, 2'b00, 1'b0, 2'd0, 32'h1234_5678, 2, 1);
    do_load(5'd4, 2'b00, 1'b0, 2'd0, 32'h1111_2222, 1, 2);
    do_load(5'd6, 2'b10, 1'b0, 2'd1, 32'h3333_4444, 0, 3);
    do_alu(1'b1, 5'd0, 32'hCAFE_F00D, 1'b0);
    do_alu(1'b1, 5'd8, 32'hCAFE_F00D, 1'b1);
    do_load(5'd10, 2'b11, 1'b1, 2'd3, 32'h8765_4321, 0, 0);
    chk("plan.rsvd", rf_wdata_o, 32'h8765_4321);

    // Back-to-back non-loads: one write every cycle.
    put_ex(1'b1, 5'd11, 32'h0000_0011, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0);
    step();
    chk_ctl("b2b.0", 1'b1, 1'b1, 1'b0);
    chk("b2b.0.d", rf_wdata_o, 32'h0000_0011);
    put_ex(1'b1, 5'd12, 32'h0000_0022, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0);
    step();
    idle_in();
    chk_ctl("b2b.1", 1'b1, 1'b1, 1'b0);
    chk("b2b.1.a", 32'(rf_waddr_o), 32'd12);
    chk("b2b.1.d", rf_wdata_o, 32'h0000_0022);
    step();
    chk_ctl("b2b.end", 1'b0, 1'b1, 1'b0);

    // Reset mid-load, then a stray response arriving in IDLE.
    put_ex(1'b1, 5'd13, 32'h0, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0);
    step();
    idle_in();
    chk_ctl("rst.wait", 1'b0, 1'b0, 1'b0);
    #2 rst_n = 0;
    #1;
    chk_ctl("rst.mid", 1'b0, 1'b1, 1'b0);
    rst_n = 1;
    step();
    lsu_rvalid_i = 1; lsu_rdata_i = 32'hFFFF_FFFF;
    step();
    idle_in();
    chk_ctl("stray", 1'b0, 1'b1, 1'b0);

    // Randomized transactions.
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 2) == 0)
        do_alu(1'($urandom), 5'($urandom), $urandom, $urandom_range(0, 3) == 0);
      else
        do_load(5'($urandom), 2'($urandom), 1'($urandom), 2'($urandom), $urandom,
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
